multdiv_seq: RTL

- Iterative signed 32-bit multiply/divide unit that sits beside the ALU in the execute stage.
- The execute stage pulses a start control with bypassed operands. The unit computes over a fixed number of cycles, then presents the result and a one-cycle ready strobe.
- The pipeline's multdiv stall holds all latches from start until the ready strobe, then latches the result into the execute/memory latch.

---
 rtl/multdiv_pkg.sv | 18 +
 rtl/multdiv_seq_div_step.sv | 21 ++
 rtl/multdiv_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: state encoding,
// default widths and the signed corner-case constants.
package multdiv_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MULT = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/multdiv_seq_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] shifted;
    logic [W:0] diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, divisor_i};
    assign q_o     = (shifted >= {1'b0, divisor_i});
    assign rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide, DATA_W cycles per operation plus a DONE
// strobe cycle. Define MULTDIV_ZERO_EARLY_EN to finish zero-operand cases early.
module multdiv_seq #(
    parameter int DATA_W = multdiv_pkg::DATA_W,
    parameter int CNT_W  = multdiv_pkg::CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    output logic [DATA_W-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);
    import multdiv_pkg::*;

    // Handshake: a start is taken in IDLE when exactly one of ctrl_MULT/ctrl_DIV
    // is high; data_resultRDY is a one-cycle strobe, result/exception held after.
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   shr_q, shr_d;
    logic                neg_q, neg_d;
    logic                dz_q, dz_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                exc_q, exc_d;

    logic                start_mult, start_div, last_iter;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   mult_hi, mult_lo;
    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W-1:0]   rem_n, div_quo, quo_s;
    logic                q_n;

    assign start_mult = ctrl_MULT & ~ctrl_DIV;
    assign start_div  = ctrl_DIV & ~ctrl_MULT;
    assign last_iter  = (cnt_q == CNT_W'(DATA_W - 1));
    assign mag_a      = data_operandA[DATA_W-1] ? -data_operandA : data_operandA;
    assign mag_b      = data_operandB[DATA_W-1] ? -data_operandB : data_operandB;

    // Multiply: acc holds the running high half, shr the multiplier/low half.
    assign sum     = {1'b0, acc_q} + (shr_q[0] ? {1'b0, a_q} : '0);
    assign mult_hi = sum[DATA_W:1];
    assign mult_lo = {sum[0], shr_q[DATA_W-1:1]};
    assign prod_s  = neg_q ? -{mult_hi, mult_lo} : {mult_hi, mult_lo};

    // Divide: acc is the partial remainder, shr shifts dividend out, quotient in.
    div_step #(.W(DATA_W)) u_div_step (
        .rem_i     (acc_q),
        .bit_i     (shr_q[DATA_W-1]),
        .divisor_i (a_q),
        .rem_o     (rem_n),
        .q_o       (q_n)
    );
    assign div_quo = {shr_q[DATA_W-2:0], q_n};
    assign quo_s   = neg_q ? -div_quo : div_quo;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        acc_d    = acc_q;
        shr_d    = shr_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        case (state_q)
            IDLE: begin
                if (start_mult || start_div) begin
                    a_d      = start_mult ? mag_a : mag_b;
                    shr_d    = start_mult ? mag_b : mag_a;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
                    dz_d     = start_div && (data_operandB == '0);
                    ovf_d    = start_div && (data_operandA == INT_MIN) &&
                               (data_operandB == NEG_ONE);
                    result_d = '0;
                    exc_d    = 1'b0;
                    state_d  = start_mult ? MULT : DIV;
`ifdef MULTDIV_ZERO_EARLY_EN
                    if ((start_mult && (data_operandA == '0 || data_operandB == '0)) ||
                        (start_div && (data_operandA == '0 || data_operandB == '0))) begin
                        exc_d   = start_div && (data_operandB == '0);
                        state_d = DONE;
                    end
`endif
                end
            end
            MULT: begin
                acc_d = mult_hi;
                shr_d = mult_lo;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    cnt_d    = '0;
                    state_d  = DONE;
                    result_d = prod_s[DATA_W-1:0];
                    exc_d    = !((&prod_s[2*DATA_W-1:DATA_W-1]) ||
                                 (~|prod_s[2*DATA_W-1:DATA_W-1]));
                end
            end
            DIV: begin
                acc_d = rem_n;
                shr_d = div_quo;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    cnt_d    = '0;
                    state_d  = DONE;
                    result_d = dz_q ? '0 : quo_s;
                    exc_d    = dz_q | ovf_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            shr_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            shr_q    <= shr_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE);
    assign dbg_state_o    = state_q;

endmodule
